// File: rtl/rs_encoder.sv
// rs_encoder: systematic GF(2^8) RS encoder, 16 parity symbols per K_BEATS-beat codeword; RS_ENC_ERR_INJ_EN adds err_mask XOR on data_out
module rs_encoder #(
    parameter int K_BEATS = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         valid_in,
    output logic         ready_in,
    output logic [127:0] data_out,
    output logic         valid_out,
    input  logic         ready_out,
    output logic         last_out
`ifdef RS_ENC_ERR_INJ_EN
    ,
    input  logic [127:0] err_mask
`endif
);
    typedef enum logic {MSG, PAR} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [15:0][7:0] gen_poly();
        logic [16:0][7:0] g;
        logic [7:0]       r;
        g    = '0;
        g[0] = 8'h01;
        r    = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], r);
            g[0] = gf_mul(g[0], r);
            r    = gf_mul(r, 8'h02);
        end
        return g[15:0];
    endfunction

    localparam logic [15:0][7:0] G_LOW = gen_poly();

    function automatic logic [15:0][7:0] mul_g(input logic [7:0] f);
        logic [15:0][7:0] p;
        for (int k = 0; k < 16; k++) p[k] = gf_mul(f, G_LOW[k]);
        return p;
    endfunction

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic [15:0][7:0] rem, rem_nxt;
    logic [7:0]       fb;
    logic [127:0]     mask;
    logic             acc, par_ld, free;

`ifdef RS_ENC_ERR_INJ_EN
    assign mask = err_mask;
`else
    assign mask = '0;
`endif

    // one beat = 16 unrolled LFSR division steps, highest-degree symbol first
    always_comb begin
        rem_nxt = rem;
        fb      = '0;
        for (int s = 15; s >= 0; s--) begin
            fb      = data_in[8*s +: 8] ^ rem_nxt[15];
            rem_nxt = {rem_nxt[14:0], 8'h00} ^ mul_g(fb);
        end
    end

    always_comb begin
        free      = !valid_out || ready_out;
        ready_in  = (state == MSG) && free;
        acc       = valid_in && ready_in;
        par_ld    = (state == PAR) && free;
        state_nxt = state == MSG ? ((acc && cnt == 4'(K_BEATS - 1)) ? PAR : MSG)
                                 : (par_ld ? MSG : PAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MSG;
            cnt       <= '0;
            rem       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                data_out  <= data_in ^ mask;
                last_out  <= 1'b0;
                valid_out <= 1'b1;
                rem       <= rem_nxt;
                cnt       <= cnt == 4'(K_BEATS - 1) ? 4'd0 : cnt + 4'd1;
            end else if (par_ld) begin
                data_out  <= rem ^ mask;
                last_out  <= 1'b1;
                valid_out <= 1'b1;
                rem       <= '0;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs_encoder.sv
// tb_rs_encoder: scoreboard bench with long-division reference model and syndrome check of every emitted codeword
module tb_rs_encoder;
    localparam int K = 14;
    localparam int N = 16 * K;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic         valid_in;
    logic         ready_in;
    logic [127:0] data_out;
    logic         valid_out;
    logic         ready_out;
    logic         last_out;
    logic [127:0] err_mask;

    rs_encoder #(.K_BEATS(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .last_out  (last_out)
`ifdef RS_ENC_ERR_INJ_EN
        ,
        .err_mask  (err_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic         l;
        logic         bad;
    } exp_t;

    exp_t       sb[$];
    int         comps = 0;
    int         errs = 0;
    int         bubbles = 0;
    bit         rand_ready = 0;
    bit         gaps = 0;
    int         alog [0:254];
    int         lg [0:255];
    logic [7:0] g [0:16];
    logic [7:0] msg [0:N-1];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return 8'(alog[(lg[a] + lg[b]) % 255]);
    endfunction

    function automatic logic [127:0] beat(input int b);
        logic [127:0] w;
        for (int s = 0; s < 16; s++) w[8*s +: 8] = msg[16*b + 15 - s];
        return w;
    endfunction

    // plain polynomial long division of m(x)*x^16 by g(x)
    function automatic logic [127:0] model_parity();
        logic [7:0]   r [0:N+15];
        logic [127:0] p;
        logic [7:0]   c;
        for (int i = 0; i < N + 16; i++) r[i] = i < N ? msg[i] : 8'h00;
        for (int i = 0; i < N; i++) begin
            c = r[i];
            if (c != 0) for (int j = 1; j <= 16; j++) r[i+j] ^= gmul(g[16-j], c);
        end
        for (int k = 0; k < 16; k++) p[8*k +: 8] = r[N + 15 - k];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        comps++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [127:0] m);
        bit acc = 0;
        int n = 0;
        valid_in = 1'b1;
        data_in  = d;
        err_mask = m;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            comps++;
            errs++;
            $display("FAIL accept_timeout: beat %h not accepted in %0d cycles", d, n);
        end
        valid_in = 1'b0;
        err_mask = '0;
        while (gaps && $urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cw(input logic [127:0] par, input int bad);
        logic [127:0] m;
        for (int b = 0; b < K; b++) begin
            m = b == bad ? 128'hff : 128'h0;
            sb.push_back('{beat(b) ^ m, 1'b0, 1'b0});
        end
        sb.push_back('{par, 1'b1, bad >= 0});
        for (int b = 0; b < K; b++) send_beat(beat(b), b == bad ? 128'hff : 128'h0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            comps++;
            errs++;
            $display("FAIL drain_timeout: %0d beats still expected, want 0", sb.size());
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: pops expected beats, checks hold stability and codeword syndromes
    logic [7:0]   syn [0:15];
    bit           hold = 0;
    logic [127:0] hold_d;
    logic         hold_l;
    exp_t         e;
    initial begin
        for (int i = 0; i < 16; i++) syn[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (hold) chk("hold_stable", {valid_out, last_out, data_out}, {1'b1, hold_l, hold_d});
            hold   = valid_out && !ready_out && !rst;
            hold_d = data_out;
            hold_l = last_out;
            if (!ready_in) bubbles++;
            if (valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    comps++;
                    errs++;
                    $display("FAIL unexpected_beat: got %h last %b, want no beat", data_out, last_out);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {last_out, data_out}, {e.l, e.d});
                    for (int s = 15; s >= 0; s--)
                        for (int i = 0; i < 16; i++) syn[i] = gmul(syn[i], 8'(alog[i])) ^ data_out[8*s +: 8];
                    if (last_out) begin
                        logic nz = 1'b0;
                        for (int i = 0; i < 16; i++) nz |= syn[i] != 0;
                        chk("syndrome_nonzero", 128'(nz), 128'(e.bad));
                        for (int i = 0; i < 16; i++) syn[i] = 8'h00;
                    end
                end
            end
            if (rst) for (int i = 0; i < 16; i++) syn[i] = 8'h00;
        end
    end

    initial begin
        logic [7:0]   x;
        logic [127:0] gw;
        int           b0;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = int'(x);
            lg[x]   = i;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
        end
        for (int i = 0; i < 17; i++) g[i] = i == 0 ? 8'h01 : 8'h00;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ gmul(g[j], 8'(alog[i]));
            g[0] = gmul(g[0], 8'(alog[i]));
        end
        rst = 1'b1; valid_in = 1'b0; data_in = '0; err_mask = '0; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_out", 128'(valid_out), 128'd0);
        chk("rst_last_out", 128'(last_out), 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_ready_in", 128'(ready_in), 128'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) msg[i] = 8'h00;
        b0 = bubbles;
        send_cw('0, -1);
        repeat (3) @(negedge clk);
        chk("zero_cw_bubbles", 128'(bubbles - b0), 128'd1);
        @(posedge clk);
        #1;
        msg[N-1] = 8'h01;
        for (int k = 0; k < 16; k++) gw[8*k +: 8] = g[k];
        send_cw(gw, -1);
        for (int c = 0; c < 1000; c++) begin
            if (c == 600) begin
                rand_ready = 1;
                gaps       = 1;
            end
            for (int i = 0; i < N; i++) msg[i] = 8'($urandom);
            send_cw(model_parity(), -1);
        end
        drain();
        rand_ready = 0;
        gaps       = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) msg[i] = 8'($urandom);
        for (int b = 0; b < 7; b++) sb.push_back('{beat(b), 1'b0, 1'b0});
        for (int b = 0; b < 7; b++) send_beat(beat(b), '0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_valid_out", 128'(valid_out), 128'd0);
        chk("abort_last_out", 128'(last_out), 128'd0);
        chk("abort_data_out", data_out, 128'd0);
        chk("abort_ready_in", 128'(ready_in), 128'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) msg[i] = 8'($urandom);
        send_cw(model_parity(), -1);
`ifdef RS_ENC_ERR_INJ_EN
        for (int i = 0; i < N; i++) msg[i] = 8'($urandom);
        send_cw(model_parity(), 3);
        for (int i = 0; i < N; i++) msg[i] = 8'($urandom);
        send_cw(model_parity(), -1);
`endif
        drain();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end
endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon encoder over GF(2^8): 16 parity symbols (t = 8), shortened code RS(16·(K_BEATS+1), 16·K_BEATS), 16 symbols per 128-bit beat. It is the transmit-side counterpart of the 16-root syndrome calculator. Message beats pass through unchanged, and one parity beat is appended per codeword. Its codewords must produce all-zero syndromes at the decoder front end.

## Interface
- K_BEATS, 14, message beats per codeword; legal range 1..14, so codeword ≤ 240 bytes ≤ 255.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- data_in  in  128  message beat; bits [127:120] are the highest-degree symbol of the beat
- valid_in  in  1  data_in valid
- ready_in  out  1  encoder accepts data_in this cycle
- data_out  out  128  codeword beat, same byte order
- valid_out  out  1  data_out valid
- ready_out  in  1  downstream accepts data_out
- last_out  out  1  data_out is the parity beat (end of codeword)

## Operation
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D). α = 0x02.
- Generator: g(x) = ∏_{i=0..15} (x − α^i). Roots match syndrome indices 0..15.
- Codeword: c(x) = m(x)·x^16 + (m(x)·x^16 mod g(x)). The message is sent first, highest-degree symbol first.
- Remainder register: 16 bytes, rem[15..0]. Per accepted beat, the 16-step LFSR division is unrolled combinationally and processes symbols from byte 15 down to byte 0.
  - Per step: fb = sym ⊕ rem[15]; rem = (rem << 8) ⊕ fb·g_low.
  - Multiplications are constant GF multipliers.
- Parity beat: data_out[8k+7:8k] = rem[k], so rem[15] goes in [127:120].
- Beat counter `cnt` (4 bits) counts accepted message beats.
- State machine:
  - MSG: ready_in = !valid_out || ready_out.
    - On accept (valid_in && ready_in): the output register loads data_in with last_out = 0, and rem is updated.
    - If cnt == K_BEATS−1, the counter resets to 0 and the state moves to PAR. Otherwise cnt increments.
  - PAR: ready_in = 0.
    - When !valid_out || ready_out: the output register loads rem with last_out = 1, rem clears to 0, and the state moves to MSG.
- Output register holds its value while valid_out && !ready_out. data_out and last_out are stable until the beat is taken.
- No gaps are required in input traffic; valid_in may drop between beats at any time.
- rst mid-codeword: the partial codeword is discarded, with no parity emitted. Any beat held in the output register is dropped.

## Timing
- Reset values: state = MSG, cnt = 0, rem = 0, valid_out = 0, last_out = 0, data_out = 0. ready_in = 1 in the first cycle after reset.
- Latency: a message beat accepted at edge T appears on data_out after edge T.
- Parity: the last message beat is accepted at edge T. Parity is presented after edge T+1 if ready_out was high at T+1.
- Throughput: with ready_out = 1 continuously, output is K_BEATS+1 beats back-to-back per codeword. There is exactly one input bubble (ready_in = 0) per codeword.
- Backpressure in PAR: stays in PAR until the output register frees. The parity value is frozen, because rem changes only on accept or on parity load.
- No combinational path from valid_in to valid_out. ready_in depends combinationally on ready_out only.

## Configuration
- RS_ENC_ERR_INJ_EN defined:
  - Adds port err_mask  in  128, sampled when a beat loads into the output register.
  - data_out = beat ⊕ err_mask. rem is always computed from the clean data.
- RS_ENC_ERR_INJ_EN not defined: port absent, no XOR, data_out is the clean beat.

## Test plan
- All-zero message, K_BEATS = 14, ready_out = 1:
  - 14 zero beats, then a parity beat of 0 with last_out = 1.
  - Exactly one ready_in = 0 cycle.
- Single symbol 0x01 at data_in[7:0] of the final message beat, rest zero:
  - The parity beat equals the low coefficients of g(x), g15..g0, in bytes 15..0.
  - These match the golden-model constants.
- 1000 random codewords, encoder output fed to the syndrome block → every syndrome_out == 0.
- Random ready_out (50% duty) and random valid_in gaps → output stream is bit-identical to the ready_out = 1 run. data_out is stable whenever valid_out && !ready_out.
- Assert rst after 7 message beats, then send a full codeword:
  - Outputs 0 the cycle after reset.
  - No parity emitted for the aborted codeword.
  - The next codeword's parity matches the golden model.
- With RS_ENC_ERR_INJ_EN:
  - err_mask = 0x…FF on one message beat → the decoder sees nonzero syndromes.
  - err_mask = 0 → all syndromes zero.
